// File: rtl/sif_pkg.sv
// Shared types and helpers for the slave serial front end:
// state encoding, bit-counter sizing and the read-latency range check.
package sif_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_WDATA   = 3'd2,
        S_MEM_WR  = 3'd3,
        S_MEM_RD  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_TX      = 3'd6
    } sif_state_t;

    localparam int SIF_RD_LAT_MIN = 1;
    localparam int SIF_RD_LAT_MAX = 4;

    // Counter must hold the value LEN (one past the last bit) without wrapping.
    function automatic int sif_cnt_width(input int a_len, input int d_len);
        return $clog2(((a_len > d_len) ? a_len : d_len) + 1);
    endfunction

    function automatic bit sif_rd_lat_ok(input int lat);
        return (lat >= SIF_RD_LAT_MIN) && (lat <= SIF_RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/sif_shifter.sv
// LSB-first shift register with a bit counter.
// load has priority; a shift on the same cycle as clr restarts the count at 1,
// so a bit captured on the entry cycle of a phase is counted correctly.
module sif_shifter #(
    parameter int W  = 8,
    parameter int CW = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] data,
    output logic         last,
    output logic         lsb
);

    logic [CW-1:0] cnt;

    // Shift/load the data register and track how many bits have moved.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data <= '0;
            cnt  <= '0;
        end else if (load) begin
            data <= load_val;
            cnt  <= '0;
        end else if (shift_en) begin
            data <= {din, data[W-1:1]};
            cnt  <= clr ? CW'(1) : cnt + CW'(1);
        end else if (clr) begin
            cnt <= '0;
        end
    end

    assign last = (cnt == CW'(W - 1));
    assign lsb  = data[0];

endmodule

// File: rtl/slave_serial_if.sv
// Slave-side serial front end: deserialises address/write data, issues one
// parallel RAM access, serialises read data back.
// Optional stall timeout with err output: define SLAVE_SIF_TIMEOUT_EN.
// Handshake: a serial bit moves from master to slave on a cycle where
// slave_ready and master_valid are both high; a tx bit moves from slave to
// master on a cycle where slave_valid and master_ready are both high.
module slave_serial_if
    import sif_pkg::*;
#(
    parameter int ADDR_LEN   = 12,
    parameter int DATA_LEN   = 8,
    parameter int RD_LATENCY = 1,
    parameter int TIMEOUT    = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                read_en,
    input  logic                write_en,
    input  logic                master_valid,
    input  logic                master_ready,
    input  logic                rx_address,
    input  logic                rx_data,
    output logic                slave_ready,
    output logic                slave_valid,
    output logic                tx_data,
    output logic                rx_done,
    output logic                slave_tx_done,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic                mem_wen,
    output logic                mem_ren,
    input  logic [DATA_LEN-1:0] mem_rdata,
`ifdef SLAVE_SIF_TIMEOUT_EN
    output logic                err,
`endif
    output logic [2:0]          dbg_state
);

    localparam int CW = sif_cnt_width(ADDR_LEN, DATA_LEN);

    if (!sif_rd_lat_ok(RD_LATENCY)) begin : g_bad_rd_latency
        $error("slave_serial_if: RD_LATENCY must be 1..4");
    end

    sif_state_t state, next_state;

    logic                op_write;
    logic                accept;
    logic                addr_shift, data_shift, tx_shift, tx_load;
    logic [ADDR_LEN-1:0] addr_sh;
    logic [DATA_LEN-1:0] data_sh;
    logic                addr_last, data_last, tx_last, tx_bit;
    logic                addr_lsb_unused, data_lsb_unused;
    logic [DATA_LEN-1:0] tx_data_unused;
    logic [2:0]          wait_cnt;
    logic                timeout_hit;

    sif_shifter #(.W(ADDR_LEN), .CW(CW)) u_addr_rx (
        .clk(clk), .reset(reset), .clr(state != S_ADDR), .shift_en(addr_shift),
        .din(rx_address), .load(1'b0), .load_val('0),
        .data(addr_sh), .last(addr_last), .lsb(addr_lsb_unused)
    );

    sif_shifter #(.W(DATA_LEN), .CW(CW)) u_data_rx (
        .clk(clk), .reset(reset), .clr(state != S_WDATA), .shift_en(data_shift),
        .din(rx_data), .load(1'b0), .load_val('0),
        .data(data_sh), .last(data_last), .lsb(data_lsb_unused)
    );

    sif_shifter #(.W(DATA_LEN), .CW(CW)) u_data_tx (
        .clk(clk), .reset(reset), .clr(1'b0), .shift_en(tx_shift),
        .din(1'b0), .load(tx_load), .load_val(mem_rdata),
        .data(tx_data_unused), .last(tx_last), .lsb(tx_bit)
    );

`ifdef SLAVE_SIF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] to_cnt;
    logic          stalled;

    assign stalled = (((state == S_ADDR) || (state == S_WDATA)) && !master_valid)
                   || ((state == S_TX) && !master_ready);
    assign timeout_hit = stalled && (to_cnt == TW'(TIMEOUT - 1));
    assign err = timeout_hit;

    // Count consecutive stalled cycles; any handshake or state change clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (stalled && !timeout_hit) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // Remember the operation chosen at acceptance; later enables are ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      op_write <= 1'b0;
        else if (accept) op_write <= write_en;
    end

    // Cycles spent waiting for RAM read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                  wait_cnt <= '0;
        else if (state == S_RD_WAIT) wait_cnt <= wait_cnt + 3'd1;
        else                         wait_cnt <= '0;
    end

    // RAM address/data registers change only when the access is committed,
    // so they hold steady while the next transfer is shifting in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if (state == S_ADDR && master_valid && addr_last && !op_write)
                mem_addr <= {rx_address, addr_sh[ADDR_LEN-1:1]};
            if (state == S_WDATA && master_valid && data_last) begin
                mem_addr  <= addr_sh;
                mem_wdata <= {rx_data, data_sh[DATA_LEN-1:1]};
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        addr_shift    = 1'b0;
        data_shift    = 1'b0;
        tx_shift      = 1'b0;
        tx_load       = 1'b0;
        slave_ready   = 1'b0;
        slave_valid   = 1'b0;
        tx_data       = 1'b0;
        rx_done       = 1'b0;
        slave_tx_done = 1'b0;
        mem_wen       = 1'b0;
        mem_ren       = 1'b0;
        unique case (state)
            S_IDLE: begin
                slave_ready = 1'b1;
                if (master_valid && (write_en || read_en)) begin
                    accept     = 1'b1;
                    addr_shift = 1'b1;
                    next_state = S_ADDR;
                end
            end
            S_ADDR: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    addr_shift = 1'b1;
                    if (addr_last) next_state = op_write ? S_WDATA : S_MEM_RD;
                end
            end
            S_WDATA: begin
                slave_ready = 1'b1;
                if (master_valid) begin
                    data_shift = 1'b1;
                    if (data_last) next_state = S_MEM_WR;
                end
            end
            S_MEM_WR: begin
                mem_wen    = 1'b1;
                rx_done    = 1'b1;
                next_state = S_IDLE;
            end
            S_MEM_RD: begin
                mem_ren    = 1'b1;
                next_state = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_cnt == 3'(RD_LATENCY - 1)) begin
                    tx_load    = 1'b1;
                    next_state = S_TX;
                end
            end
            S_TX: begin
                slave_valid = 1'b1;
                tx_data     = tx_bit;
                if (master_ready) begin
                    tx_shift = 1'b1;
                    if (tx_last) begin
                        slave_tx_done = 1'b1;
                        next_state    = S_IDLE;
                    end
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (timeout_hit) next_state = S_IDLE;
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_slave_serial_if.sv
// Directed bench for slave_serial_if with a one-cycle-latency RAM model.
// Build with SLAVE_SIF_TIMEOUT_EN defined to also exercise the stall timeout.
module tb_slave_serial_if;

    localparam int AL = 12;
    localparam int DL = 8;
    localparam int RL = 1;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_en, write_en, master_valid, master_ready;
    logic          rx_address, rx_data;
    logic          slave_ready, slave_valid, tx_data, rx_done, slave_tx_done;
    logic [AL-1:0] mem_addr;
    logic [DL-1:0] mem_wdata;
    logic          mem_wen, mem_ren;
    logic [DL-1:0] mem_rdata = '0;
    logic [2:0]    dbg_state;
`ifdef SLAVE_SIF_TIMEOUT_EN
    logic          err;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int wen_total   = 0;
    int ren_total   = 0;
    int rxd_total   = 0;

    logic [DL-1:0] ram [0:(1<<AL)-1];

    slave_serial_if #(.ADDR_LEN(AL), .DATA_LEN(DL), .RD_LATENCY(RL), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .read_en(read_en), .write_en(write_en),
        .master_valid(master_valid), .master_ready(master_ready),
        .rx_address(rx_address), .rx_data(rx_data),
        .slave_ready(slave_ready), .slave_valid(slave_valid), .tx_data(tx_data),
        .rx_done(rx_done), .slave_tx_done(slave_tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata),
`ifdef SLAVE_SIF_TIMEOUT_EN
        .err(err),
`endif
        .dbg_state(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // RAM model: synchronous write, read data valid the cycle after mem_ren.
    always @(posedge clk) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    // Strobe counters sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_wen) wen_total++;
        if (mem_ren) ren_total++;
        if (rx_done) rxd_total++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a full write; cycle 1 is the acceptance cycle. stall_n idle
    // cycles are inserted before serial bit index stall_at.
    task automatic write_op(input logic [AL-1:0] a, input logic [DL-1:0] d,
                            input int stall_at, input int stall_n, input bit both,
                            output int wen_cyc, output logic [AL-1:0] a_obs,
                            output logic [DL-1:0] d_obs, output logic rxd_obs,
                            output int ready_low);
        logic [AL+DL-1:0] bits;
        int idx;
        int cyc;
        int stalls;
        bits = {d, a};
        idx = 0; cyc = 0; stalls = 0;
        wen_cyc = -1; a_obs = '0; d_obs = '0; rxd_obs = 1'b0; ready_low = 0;
        while (idx < AL + DL) begin
            if (idx == stall_at && stalls < stall_n) begin
                master_valid = 1'b0;
                stalls++;
            end else begin
                master_valid = 1'b1;
                rx_address   = bits[idx];
                rx_data      = bits[idx];
                idx++;
            end
            write_en = (cyc == 0);
            read_en  = both && (cyc == 0);
            cyc++;
            @(negedge clk);
            if (!slave_ready) ready_low++;
            if (mem_wen && wen_cyc < 0) begin
                wen_cyc = cyc; a_obs = mem_addr; d_obs = mem_wdata; rxd_obs = rx_done;
            end
            tick();
        end
        master_valid = 1'b0; write_en = 1'b0; read_en = 1'b0;
        for (int k = 0; k < 5 && wen_cyc < 0; k++) begin
            cyc++;
            @(negedge clk);
            if (mem_wen) begin
                wen_cyc = cyc; a_obs = mem_addr; d_obs = mem_wdata; rxd_obs = rx_done;
            end
            tick();
        end
    endtask

    // Drive a read and collect accepted tx bits. toggle=1 drives master_ready
    // 1,0,1,0... over the TX cycles.
    task automatic read_op(input logic [AL-1:0] a, input bit toggle,
                           output logic [DL-1:0] rbits, output int nacc,
                           output int first_tx, output int done_cyc,
                           output int rdy_tx, output int hold_err);
        int cyc;
        int txc;
        logic held;
        logic prev_bit;
        cyc = 0; txc = 0; held = 1'b0; prev_bit = 1'b0;
        rbits = '0; nacc = 0; first_tx = -1; done_cyc = -1; rdy_tx = 0; hold_err = 0;
        master_ready = 1'b1;
        for (int i = 0; i < AL; i++) begin
            master_valid = 1'b1;
            read_en      = (i == 0);
            rx_address   = a[i];
            cyc++;
            tick();
        end
        master_valid = 1'b0; read_en = 1'b0;
        for (int k = 0; k < 60 && done_cyc < 0; k++) begin
            master_ready = toggle ? (txc % 2 == 0) : 1'b1;
            cyc++;
            @(negedge clk);
            if (slave_valid) begin
                if (first_tx < 0) first_tx = cyc;
                if (slave_ready) rdy_tx++;
                if (held && tx_data !== prev_bit) hold_err++;
                if (master_ready) begin
                    if (nacc < DL) rbits[nacc] = tx_data;
                    nacc++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    prev_bit = tx_data;
                end
                txc++;
            end
            if (slave_tx_done) done_cyc = cyc;
            tick();
        end
        master_ready = 1'b0;
    endtask

    int            wc, rl, nacc, ftx, dc, rdy, herr, wen0, ren0, rxd0;
    logic [AL-1:0] ao;
    logic [DL-1:0] dobs, rb;
    logic          rxd;
    logic [AL+DL-1:0] pbits;

    initial begin
        reset = 1'b0; read_en = 1'b0; write_en = 1'b0; master_valid = 1'b0;
        master_ready = 1'b0; rx_address = 1'b0; rx_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset values.
        chk("rst_slave_ready", slave_ready, 1);
        chk("rst_slave_valid", slave_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_done", rx_done, 0);
        chk("rst_tx_done", slave_tx_done, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_ren", mem_ren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_state", dbg_state, 0);
        reset = 1'b1;
        tick();

        // 1: write A5C <- 3E, no stalls.
        write_op(12'hA5C, 8'h3E, 99, 0, 1'b0, wc, ao, dobs, rxd, rl);
        chk("t1_wen_cycle", wc, 21);
        chk("t1_mem_addr", ao, 12'hA5C);
        chk("t1_mem_wdata", dobs, 8'h3E);
        chk("t1_rx_done", rxd, 1);
        chk("t1_ready_low", rl, 0);
        chk("t1_wen_pulses", wen_total, 1);
        chk("t1_rxd_pulses", rxd_total, 1);
        chk("t1_mem_addr_hold", mem_addr, 12'hA5C);

        // 2: read A5C, master_ready always high.
        read_op(12'hA5C, 1'b0, rb, nacc, ftx, dc, rdy, herr);
        chk("t2_rbits", rb, 8'h3E);
        chk("t2_nacc", nacc, 8);
        chk("t2_first_tx", ftx, 15);
        chk("t2_done_cycle", dc, 22);
        chk("t2_ready_in_tx", rdy, 0);
        chk("t2_ren_pulses", ren_total, 1);
        @(negedge clk);
        chk("t2_valid_after", slave_valid, 0);
        chk("t2_state_after", dbg_state, 0);
        tick();

        // 3: write 001 <- FF with 3 stall cycles mid-address.
        write_op(12'h001, 8'hFF, 5, 3, 1'b0, wc, ao, dobs, rxd, rl);
        chk("t3_wen_cycle", wc, 24);
        chk("t3_mem_addr", ao, 12'h001);
        chk("t3_mem_wdata", dobs, 8'hFF);
        chk("t3_rx_done", rxd, 1);

        // 4: read A5C with master_ready toggling.
        read_op(12'hA5C, 1'b1, rb, nacc, ftx, dc, rdy, herr);
        chk("t4_rbits", rb, 8'h3E);
        chk("t4_nacc", nacc, 8);
        chk("t4_first_tx", ftx, 15);
        chk("t4_done_cycle", dc, 29);
        chk("t4_hold_err", herr, 0);

        // 5a: both enables high -> write wins.
        ren0 = ren_total;
        write_op(12'h7FF, 8'h81, 99, 0, 1'b1, wc, ao, dobs, rxd, rl);
        chk("t5_wen_cycle", wc, 21);
        chk("t5_mem_addr", ao, 12'h7FF);
        chk("t5_mem_wdata", dobs, 8'h81);
        chk("t5_no_ren", ren_total, ren0);

        // 5b: reset in the middle of WDATA aborts without a strobe.
        pbits = {8'h55, 12'h123};
        for (int i = 0; i < AL + 3; i++) begin
            master_valid = 1'b1;
            write_en     = (i == 0);
            rx_address   = pbits[i];
            rx_data      = pbits[i];
            tick();
        end
        write_en = 1'b0;
        chk("t5_in_wdata", dbg_state, 2);
        wen0 = wen_total; rxd0 = rxd_total;
        #2;
        reset = 1'b0; master_valid = 1'b0;
        #1;
        chk("t5_rst_ready", slave_ready, 1);
        chk("t5_rst_state", dbg_state, 0);
        chk("t5_rst_mem_addr", mem_addr, 0);
        tick();
        reset = 1'b1;
        repeat (25) tick();
        chk("t5_abort_no_wen", wen_total, wen0);
        chk("t5_abort_no_rxd", rxd_total, rxd0);

        // 5c: normal write after the abort.
        write_op(12'h0F0, 8'h5A, 99, 0, 1'b0, wc, ao, dobs, rxd, rl);
        chk("t5_recover_cycle", wc, 21);
        chk("t5_recover_data", dobs, 8'h5A);

`ifdef SLAVE_SIF_TIMEOUT_EN
        // 6: stall after 4 address bits until the timeout fires.
        begin
            int err_cyc;
            err_cyc = -1;
            wen0 = wen_total; ren0 = ren_total;
            for (int i = 0; i < 4; i++) begin
                master_valid = 1'b1;
                write_en     = (i == 0);
                rx_address   = i[0];
                tick();
            end
            master_valid = 1'b0; write_en = 1'b0;
            for (int k = 1; k <= 20 && err_cyc < 0; k++) begin
                @(negedge clk);
                if (err) err_cyc = k;
                tick();
            end
            chk("t6_err_cycle", err_cyc, TO);
            chk("t6_state_idle", dbg_state, 0);
            @(negedge clk);
            chk("t6_err_pulse", err, 0);
            tick();
            chk("t6_no_wen", wen_total, wen0);
            chk("t6_no_ren", ren_total, ren0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slave_serial_if.md
Name: slave_serial_if

Overview:
Slave-side serial front end between the bus interconnect's per-slave serial port and a parallel block RAM. It deserialises the address and write data, issues one parallel memory access, then serialises read data back to the master. One instance sits in front of each memory slave (4k, 2k, ...), so the RAM needs only a single-cycle parallel port.

Parameters:
ADDR_LEN, 12, address bits shifted in serially; also the width of mem_addr
DATA_LEN, 8, data bits per transfer, both directions
RD_LATENCY, 1, cycles from mem_ren to valid mem_rdata; legal range 1..4
TIMEOUT, 15, idle cycles allowed mid-transfer before abort; used only with the optional feature

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
read_en  input  1  read request from master, sampled only in IDLE
write_en  input  1  write request from master, sampled only in IDLE
master_valid  input  1  rx_address/rx_data bit valid this cycle
master_ready  input  1  master accepts the tx_data bit this cycle
rx_address  input  1  serial address, LSB first
rx_data  input  1  serial write data, LSB first
slave_ready  output  1  slave can accept serial bits
slave_valid  output  1  tx_data bit valid
tx_data  output  1  serial read data, LSB first
rx_done  output  1  one-cycle pulse when a write commits
slave_tx_done  output  1  one-cycle pulse when the last read bit is accepted
mem_addr  output  ADDR_LEN  RAM address
mem_wdata  output  DATA_LEN  RAM write data
mem_wen  output  1  RAM write strobe, one cycle
mem_ren  output  1  RAM read strobe, one cycle
mem_rdata  input  DATA_LEN  RAM read data

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; slave_ready=1; every other output=0; shift registers and counters=0. Reset takes effect from any state and aborts any transfer in progress without a memory access.
- States: IDLE, ADDR, WDATA, MEM_WR, MEM_RD, RD_WAIT, TX.
- IDLE:
  - If master_valid=1 and (write_en or read_en), latch the op, capture rx_address bit0, go to ADDR.
  - Write wins if both enables are high.
  - read_en and write_en are ignored after the op is latched.
- ADDR:
  - One address bit is captured per cycle with master_valid=1; master_valid=0 stalls with no capture.
  - After ADDR_LEN bits: write goes to WDATA, read goes to MEM_RD.
- WDATA: DATA_LEN bits on rx_data, same stall rule as ADDR; then MEM_WR.
- MEM_WR: one cycle; mem_wen=1, rx_done=1; mem_addr/mem_wdata hold the assembled values; next state IDLE.
- MEM_RD: one cycle; mem_ren=1; next state RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles, then load mem_rdata into the tx shifter; go to TX.
- TX:
  - slave_valid=1 and tx_data = current bit.
  - The bit advances only on a cycle with master_ready=1. Otherwise tx_data holds.
  - On the cycle the last bit is accepted: slave_tx_done=1, next state IDLE, slave_valid=0 from the next cycle.
- slave_ready=1 in IDLE, ADDR and WDATA only; 0 in all other states.
- mem_addr and mem_wdata hold their last values when not strobed.
- Latency:
  - Write: mem_wen occurs 1 cycle after the last data bit is captured.
  - Read: first tx bit appears 1+RD_LATENCY+1 cycles after the last address bit.
- Bit counters are sized $clog2(max(ADDR_LEN,DATA_LEN)+1) and have no wrap-around. The counter compares to LEN-1 and clears on each state entry.
- Back-to-back operation: a new request can be accepted in the cycle after MEM_WR or after the final TX bit.

Optional Feature:
SLAVE_SIF_TIMEOUT_EN
- Enabled:
  - Adds output err (1 bit, reset 0).
  - In ADDR, WDATA or TX, a counter runs while the expected handshake input (master_valid, or master_ready in TX) is low. It clears whenever that input is high.
  - When the counter reaches TIMEOUT: err pulses for one cycle, the FSM goes to IDLE, no memory strobe is issued, and no done pulse is issued.
- Disabled: no err port and no counter; stalls are unbounded.

Decomposition:
- Package sif_pkg holds:
  - the state enum sif_state_t;
  - the function for counter width;
  - the RD_LATENCY bounds check constant.
- One sub-module, sif_shifter, is natural. It is a parameterised LSB-first shift register with a bit counter and load/shift/done. It is instantiated three times: address rx, data rx, data tx.

Test Plan:
1. Write with no stalls: address 0xA5C, data 0x3E. Expected: mem_wen for one cycle with mem_addr=0xA5C and mem_wdata=0x3E, 21 cycles after entry; rx_done coincides with it.
2. Read back 0xA5C with the RAM model returning 0x3E and master_ready=1. Expected: tx_data bits 0,1,1,1,1,1,0,0, then slave_tx_done; slave_ready=0 throughout TX.
3. Write with master_valid low for 3 cycles mid-address, address 0x001, data 0xFF. Expected: correct values written, and completion delayed by exactly 3 cycles.
4. Read with master_ready toggling 1,0,1,0... Expected: each bit held while master_ready=0; 8 accepted bits, then slave_tx_done.
5. read_en and write_en both high at start, address 0x7FF, data 0x81. Expected: the write is performed and mem_ren is never asserted. Then assert reset for one cycle during WDATA: no mem_wen, and slave_ready=1 immediately.
6. With SLAVE_SIF_TIMEOUT_EN defined and TIMEOUT=15, hold master_valid=0 after 4 address bits. Expected: err pulses on the 15th idle cycle, state is IDLE, and no strobe is issued.
